// File: rtl/lsu_pixel_unpacker.sv
// LSU read-side stage: fetches frame-buffer beats into a 2-entry prefetch buffer and unpacks them
// into a valid/ready pixel stream. Optional stall counter built only when UNPACK_STALL_CNT_EN is defined.
module lsu_pixel_unpacker #(
   parameter int unsigned IMAGE_DIM   = 512,
   parameter int unsigned DATA_WIDTH  = 128,
   parameter int unsigned PIXEL_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   aresetn,
   input  logic                   start,
   output logic                   busy,
   output logic                   read_enable,
   input  logic [DATA_WIDTH-1:0]  read_data,
   output logic [PIXEL_WIDTH-1:0] m_tdata,
   output logic                   m_tvalid,
   input  logic                   m_tready,
   output logic                   m_tlast,
   output logic                   m_tuser,
   output logic                   frame_done,
   output logic [31:0]            stall_cycles
);

   localparam int unsigned PIXELS_PER_BEAT = DATA_WIDTH / PIXEL_WIDTH;
   localparam int unsigned TOTAL_BEATS     = IMAGE_DIM * IMAGE_DIM / PIXELS_PER_BEAT;
   localparam int unsigned ISS_W           = $clog2(TOTAL_BEATS + 1);
   localparam int unsigned P_W             = (PIXELS_PER_BEAT > 1) ? $clog2(PIXELS_PER_BEAT) : 1;
   localparam int unsigned C_W             = (IMAGE_DIM > 1) ? $clog2(IMAGE_DIM) : 1;

   localparam logic [ISS_W-1:0] ISS_LAST = ISS_W'(TOTAL_BEATS);
   localparam logic [P_W-1:0]   P_LAST   = P_W'(PIXELS_PER_BEAT - 1);
   localparam logic [C_W-1:0]   C_LAST   = C_W'(IMAGE_DIM - 1);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   state_t                  state_q, state_d;
   logic [ISS_W-1:0]        issued_q;
   logic                    inflight_q;
   logic [DATA_WIDTH-1:0]   beat_q [2];
   logic                    wr_ptr_q, rd_ptr_q;
   logic [1:0]              count_q;
   logic [P_W-1:0]          pix_q;
   logic [C_W-1:0]          col_q, row_q;

   logic                    start_acc;
   logic                    xfer;
   logic                    pop;
   logic                    final_px;
   logic [1:0]              occ;
   logic [DATA_WIDTH-1:0]   head;
   logic [PIXEL_WIDTH-1:0]  pix_sel;

   // An empty buffer with a read in flight presents the returning beat directly, so the
   // first pixel is visible the same cycle the beat arrives; the beat is still captured.
   assign head      = (count_q == 2'd0) ? read_data : beat_q[rd_ptr_q];
   assign m_tvalid  = (count_q != 2'd0) || inflight_q;
   assign xfer      = m_tvalid && m_tready;
   assign pop       = xfer && (pix_q == P_LAST);
   assign final_px  = (row_q == C_LAST) && (col_q == C_LAST);
   assign start_acc = (state_q == IDLE) && start;
   assign occ       = count_q + 2'(inflight_q);

   always_comb begin
      pix_sel = '0;
      for (int unsigned i = 0; i < PIXELS_PER_BEAT; i++) begin
         if (pix_q == P_W'(i)) pix_sel = head[i*PIXEL_WIDTH +: PIXEL_WIDTH];
      end
   end

   // State register
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = FETCH;
         FETCH:   if (issued_q == ISS_LAST) state_d = DRAIN;
         DRAIN:   if (xfer && final_px) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      busy        = (state_q != IDLE);
      read_enable = (state_q == FETCH) && (issued_q != ISS_LAST) && (occ < 2'd2);
      frame_done  = (state_q == DRAIN) && xfer && final_px;
      m_tdata     = m_tvalid ? pix_sel : '0;
      m_tlast     = m_tvalid && (col_q == C_LAST);
      m_tuser     = m_tvalid && (row_q == '0) && (col_q == '0);
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         issued_q   <= '0;
         inflight_q <= 1'b0;
         beat_q[0]  <= '0;
         beat_q[1]  <= '0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         count_q    <= '0;
         pix_q      <= '0;
         col_q      <= '0;
         row_q      <= '0;
      end else begin
         inflight_q <= read_enable;
         if (inflight_q) begin
            beat_q[wr_ptr_q] <= read_data;
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_q + 2'(inflight_q) - 2'(pop);

         if (start_acc) begin
            issued_q <= '0;
            pix_q    <= '0;
            col_q    <= '0;
            row_q    <= '0;
         end else begin
            if (read_enable) issued_q <= issued_q + ISS_W'(1);
            if (xfer) begin
               pix_q <= (pix_q == P_LAST) ? '0 : pix_q + P_W'(1);
               if (col_q == C_LAST) begin
                  col_q <= '0;
                  row_q <= (row_q == C_LAST) ? '0 : row_q + C_W'(1);
               end else begin
                  col_q <= col_q + C_W'(1);
               end
            end
         end
      end
   end

`ifdef UNPACK_STALL_CNT_EN
   logic [31:0] stall_q;

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn)                                      stall_q <= '0;
      else if (start_acc)                                stall_q <= '0;
      else if (m_tvalid && !m_tready && (stall_q != '1)) stall_q <= stall_q + 32'd1;
   end

   assign stall_cycles = stall_q;
`else
   assign stall_cycles = '0;
`endif

endmodule
